// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_pkg                                                    |
// | Description : Shared SPI definitions: default word size, bit-counter     |
// |               width and the one-hot FSM state encoding.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package spi_pkg;

    localparam int c_default_data_size = 8;
    localparam int c_cnt_width         = 6;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_LOAD  = 4'b0010,
        ST_SHIFT = 4'b0100,
        ST_DONE  = 4'b1000
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_slave_if                                               |
// | Description : SPI pins plus TX/RX handshake of the SPI slave.            |
// |               overrun_o exists only when SPI_SLAVE_OVERRUN_EN is defined.|
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_SIZE = c_default_data_size
);
    logic                 cpol_i;
    logic                 cpha_i;
    logic                 sck_i;
    logic                 ss_i;
    logic                 mosi_i;
    logic                 miso_o;
    logic [DATA_SIZE-1:0] txdata_i;
    logic                 tx_we_i;
    logic                 tx_full_o;
    logic [DATA_SIZE-1:0] rxdata_o;
    logic                 rx_valid_o;
    logic                 rx_rd_i;
    logic                 busy_o;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                 overrun_o;
`endif

    modport slave (
        input  cpol_i, cpha_i, sck_i, ss_i, mosi_i, txdata_i, tx_we_i, rx_rd_i,
        output miso_o, tx_full_o, rxdata_o, rx_valid_o, busy_o
`ifdef SPI_SLAVE_OVERRUN_EN
        , output overrun_o
`endif
    );

    modport master (
        output cpol_i, cpha_i, sck_i, ss_i, mosi_i, txdata_i, tx_we_i, rx_rd_i,
        input  miso_o, tx_full_o, rxdata_o, rx_valid_o, busy_o
`ifdef SPI_SLAVE_OVERRUN_EN
        , input overrun_o
`endif
    );

endinterface
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_sync                                                   |
// | Description : Two-flop synchronizer with configurable reset value.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_data,
    output logic o_sync
);
    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_slave                                                  |
// | Description : SPI slave, all four modes, LSB first, single TX holding    |
// |               register, back-to-back words while ss stays low.           |
// |               Optional macro SPI_SLAVE_OVERRUN_EN adds overrun_o.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_SIZE = c_default_data_size
) (
    input  logic       clk_i,
    input  logic       rst_i,
    spi_slave_if.slave bus
);
    localparam logic [c_cnt_width-1:0] c_last = c_cnt_width'(DATA_SIZE - 1);

    logic w_ss;
    logic w_sck_act;
    logic w_sck_raw;
    logic w_mosi;

    // sck is synchronized relative to its idle level, so the reset value 0
    // means "sck at cpol" and a rising synchronized value is a leading edge.
    assign w_sck_raw = bus.sck_i ^ bus.cpol_i;

    spi_sync #(.RESET_VAL(1'b1)) u_sync_ss   (.clk_i(clk_i), .rst_i(rst_i), .i_data(bus.ss_i),   .o_sync(w_ss));
    spi_sync #(.RESET_VAL(1'b0)) u_sync_sck  (.clk_i(clk_i), .rst_i(rst_i), .i_data(w_sck_raw),  .o_sync(w_sck_act));
    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (.clk_i(clk_i), .rst_i(rst_i), .i_data(bus.mosi_i), .o_sync(w_mosi));

    logic       r_ss_d;
    logic       r_sck_d;
    logic [1:0] r_settle;

    // Edge-detect history; r_settle masks the artificial ss fall seen while
    // the synchronizer drains its reset value after reset release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ss_d   <= 1'b1;
            r_sck_d  <= 1'b0;
            r_settle <= 2'd0;
        end else begin
            r_ss_d   <= w_ss;
            r_sck_d  <= w_sck_act;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    logic w_ss_fall;
    logic w_lead;
    logic w_trail;
    logic w_sample;
    logic w_shift;

    assign w_ss_fall = r_ss_d & ~w_ss & (r_settle == 2'd3);
    assign w_lead    = w_sck_act & ~r_sck_d;
    assign w_trail   = ~w_sck_act & r_sck_d;
    assign w_sample  = bus.cpha_i ? w_trail : w_lead;
    assign w_shift   = bus.cpha_i ? w_lead  : w_trail;

    spi_state_e                r_state;
    spi_state_e                w_state_nxt;
    logic                      w_reload;
    logic                      w_done;
    logic                      w_in_word;
    logic [c_cnt_width-1:0]    r_cnt;
    logic [DATA_SIZE-1:0]      r_tx_sh;
    logic [DATA_SIZE-1:0]      r_rx_sh;
    logic [DATA_SIZE-1:0]      r_hold;
    logic                      r_tx_full;
    logic [DATA_SIZE-1:0]      r_rxdata;
    logic                      r_rx_valid;

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; w_reload marks the cycles that refill the TX shifter
    always_comb begin
        w_state_nxt = r_state;
        w_reload    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_LOAD;
                    w_reload    = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nxt = w_ss ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_ss) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sample && (r_cnt == c_last)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_ss) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                    w_reload    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_done    = (r_state == ST_DONE);
    assign w_in_word = (r_state == ST_SHIFT) && !w_ss;

    // Datapath: bit counter, shifters, holding register and RX word.
    // TX shifts only when r_cnt != 0: this skips the first cpha=1 leading
    // edge and the cpha=0 trailing edge that follows the final sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_hold     <= '0;
            r_tx_full  <= 1'b0;
            r_rxdata   <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_in_word) begin
                if (w_sample) begin
                    r_cnt   <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
                    r_rx_sh <= {w_mosi, r_rx_sh[DATA_SIZE-1:1]};
                end
            end else begin
                r_cnt <= '0;
            end

            if (w_reload) begin
                r_tx_sh   <= r_tx_full ? r_hold : '0;
                r_tx_full <= 1'b0;
            end else if (w_in_word && w_shift && (r_cnt != '0)) begin
                r_tx_sh <= {1'b0, r_tx_sh[DATA_SIZE-1:1]};
            end

            // A write in the same cycle as a reload lands after it
            if (bus.tx_we_i) begin
                r_hold    <= bus.txdata_i;
                r_tx_full <= 1'b1;
            end

            if (w_done) begin
                r_rxdata <= r_rx_sh;
            end
            r_rx_valid <= w_done;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic r_unread;
    logic r_overrun;

    // Flag a completed word that overwrites one never acknowledged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_unread  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_done) begin
                r_unread <= 1'b1;
            end else if (bus.rx_rd_i) begin
                r_unread <= 1'b0;
            end
            if (w_done && r_unread && !bus.rx_rd_i) begin
                r_overrun <= 1'b1;
            end else if (bus.rx_rd_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.overrun_o = r_overrun;
`else
    logic w_unused_rx_rd;
    assign w_unused_rx_rd = bus.rx_rd_i;
`endif

    assign bus.miso_o     = (r_state == ST_IDLE) ? 1'b0 : r_tx_sh[0];
    assign bus.tx_full_o  = r_tx_full;
    assign bus.rxdata_o   = r_rxdata;
    assign bus.rx_valid_o = r_rx_valid;
    assign bus.busy_o     = ~w_ss;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_slave                                               |
// | Description : Self-checking bench for spi_slave: bit-banged SPI master,  |
// |               holding-register model, directed and random transfers.     |
// |               Overrun checks run when SPI_SLAVE_OVERRUN_EN is defined.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_spi_slave;
    localparam int c_dw   = 8;
    localparam int c_half = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_SIZE(c_dw)) bus();
    spi_slave #(.DATA_SIZE(c_dw)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int rx_pulses = 0;
    logic [7:0] last_rx = 8'h00;

    // reference model of the holding register
    logic       m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_valid_o) begin
            rx_pulses++;
            last_rx = bus.rxdata_o;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_hold(input logic [7:0] v);
        @(negedge clk);
        bus.txdata_i = v;
        bus.tx_we_i  = 1'b1;
        m_hold = v;
        m_full = 1'b1;
        @(negedge clk);
        bus.tx_we_i = 1'b0;
    endtask

    // word start: slave sends the held word once, otherwise zero
    task automatic model_take(output logic [7:0] exp);
        exp = m_full ? m_hold : 8'h00;
        m_full = 1'b0;
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        cpol = m[1];
        cpha = m[0];
        bus.cpol_i = cpol;
        bus.cpha_i = cpha;
        bus.sck_i  = cpol;
    endtask

    task automatic ss_low();
        @(negedge clk);
        bus.ss_i = 1'b0;
        wait_clk(c_half);
    endtask

    task automatic ss_high();
        wait_clk(c_half);
        bus.ss_i = 1'b1;
        wait_clk(c_half);
    endtask

    // master side of nbits of one word, LSB first; optional holding write
    task automatic xfer_word(input logic [7:0] tx, input int nbits, input int wr_bit,
                             input logic [7:0] wr_val, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (i == wr_bit) write_hold(wr_val);
            if (!cpha) begin
                bus.mosi_i = tx[i];
                wait_clk(c_half);
                bus.sck_i = ~cpol;
                rx[i] = bus.miso_o;
                wait_clk(c_half);
                bus.sck_i = cpol;
            end else begin
                bus.sck_i  = ~cpol;
                bus.mosi_i = tx[i];
                wait_clk(c_half);
                bus.sck_i = cpol;
                rx[i] = bus.miso_o;
                wait_clk(c_half);
            end
        end
    endtask

    task automatic do_xfer(input logic [7:0] tx, input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        int p0;
        p0 = rx_pulses;
        ss_low();
        model_take(exp);
        xfer_word(tx, 8, -1, 8'h00, got);
        ss_high();
        check_eq({tag, "_miso"}, 32'(got), 32'(exp));
        check_eq({tag, "_rxdata"}, 32'(bus.rxdata_o), 32'(tx));
        check_eq({tag, "_pulses"}, 32'(rx_pulses - p0), 32'd1);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] exp;
        logic [7:0] rx_before;
        logic [7:0] unused_rx;
        logic [7:0] v;
        int p0;

        bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.sck_i = 1'b0; bus.ss_i = 1'b1;
        bus.mosi_i = 1'b0; bus.txdata_i = '0; bus.tx_we_i = 1'b0; bus.rx_rd_i = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);

        // reset state
        check_eq("rst_miso",     32'(bus.miso_o),     32'd0);
        check_eq("rst_rxdata",   32'(bus.rxdata_o),   32'd0);
        check_eq("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
        check_eq("rst_tx_full",  32'(bus.tx_full_o),  32'd0);
        check_eq("rst_busy",     32'(bus.busy_o),     32'd0);

        // mode 0 basic word
        set_mode(0);
        write_hold(8'h3C);
        check_eq("m0_tx_full_set", 32'(bus.tx_full_o), 32'd1);
        do_xfer(8'hA5, "m0");
        check_eq("m0_tx_full_clr", 32'(bus.tx_full_o), 32'd0);

        // all four modes
        for (int m = 0; m < 4; m++) begin
            set_mode(m);
            write_hold(8'h81);
            do_xfer(8'h5A, $sformatf("mode%0d", m));
        end

        // two back-to-back words, second held word written mid-first-word
        set_mode(0);
        write_hold(8'h11);
        p0 = rx_pulses;
        ss_low();
        model_take(exp);
        xfer_word(8'h96, 8, 3, 8'h22, got);
        check_eq("b2b_w1_miso", 32'(got), 32'(exp));
        wait_clk(4);
        check_eq("b2b_w1_rx", 32'(last_rx), 32'h96);
        model_take(exp);
        xfer_word(8'h69, 8, -1, 8'h00, got);
        ss_high();
        check_eq("b2b_w2_miso", 32'(got), 32'(exp));
        check_eq("b2b_w2_rx", 32'(bus.rxdata_o), 32'h69);
        check_eq("b2b_pulses", 32'(rx_pulses - p0), 32'd2);

        // abort after 3 bits; a write during the aborted word is kept
        rx_before = bus.rxdata_o;
        p0 = rx_pulses;
        ss_low();
        model_take(exp);
        xfer_word(8'hFF, 3, 1, 8'hC7, unused_rx);
        ss_high();
        check_eq("abort_pulses", 32'(rx_pulses - p0), 32'd0);
        check_eq("abort_rxdata", 32'(bus.rxdata_o), 32'(rx_before));
        check_eq("abort_busy",   32'(bus.busy_o),   32'd0);
        check_eq("abort_held",   32'(bus.tx_full_o), 32'd1);
        do_xfer(8'hF0, "after_abort");

        // reset mid-word
        ss_low();
        model_take(exp);
        write_hold(8'h77);
        xfer_word(8'h3F, 4, -1, 8'h00, unused_rx);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_miso",     32'(bus.miso_o),     32'd0);
        check_eq("midrst_rxdata",   32'(bus.rxdata_o),   32'd0);
        check_eq("midrst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
        check_eq("midrst_tx_full",  32'(bus.tx_full_o),  32'd0);
        check_eq("midrst_busy",     32'(bus.busy_o),     32'd0);
        rst = 1'b0;
        m_full = 1'b0;
        // ss never rose again: a full word of clocks must be ignored
        p0 = rx_pulses;
        wait_clk(c_half);
        xfer_word(8'hE1, 8, -1, 8'h00, unused_rx);
        ss_high();
        check_eq("postrst_pulses", 32'(rx_pulses - p0), 32'd0);
        check_eq("postrst_rxdata", 32'(bus.rxdata_o),   32'd0);
        // nothing written since reset: slave sends zero
        do_xfer(8'h4B, "no_write");

        // randomized transfers
        for (int i = 0; i < 8; i++) begin
            set_mode(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                v = 8'($urandom);
                write_hold(v);
            end
            do_xfer(8'($urandom), $sformatf("rand%0d", i));
        end

`ifdef SPI_SLAVE_OVERRUN_EN
        @(negedge clk);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        m_full = 1'b0;
        wait_clk(4);
        set_mode(0);
        do_xfer(8'h12, "ovr_w1");
        check_eq("ovr_after_w1", 32'(bus.overrun_o), 32'd0);
        do_xfer(8'h34, "ovr_w2");
        check_eq("ovr_after_w2", 32'(bus.overrun_o), 32'd1);
        @(negedge clk);
        bus.rx_rd_i = 1'b1;
        @(negedge clk);
        bus.rx_rd_i = 1'b0;
        @(negedge clk);
        check_eq("ovr_cleared", 32'(bus.overrun_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
